set_assoc_cache: RTL and testbench
==================================

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 Parameter WAYS, default 4, associativity; power of two, 2..8.
REQ-002 Parameter SETS, default 8, sets per way; power of two, >= 2.
REQ-003 Parameter LINE_BYTES, default 32, bytes per line; power of two, >= 4.
REQ-004 Parameter ADDR_W, default 32, physical address width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  1  CPU request present.
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 req_we  input  1  1 = byte write, 0 = byte read.
REQ-010 req_addr  input  ADDR_W  byte address.
REQ-011 req_wdata  input  8  write byte.
REQ-012 resp_valid  output  1  one-cycle response strobe.
REQ-013 resp_rdata  output  8  read byte; for writes, the byte as written.
REQ-014 resp_hit  output  1  1 = request hit, 0 = missed; valid with resp_valid.
REQ-015 mem_req  output  1  memory transaction request, held until mem_ack.
REQ-016 mem_we  output  1  1 = line write-back, 0 = line refill.
REQ-017 mem_addr  output  ADDR_W  line-aligned address; offset bits are zero.
REQ-018 mem_wdata  output  8*LINE_BYTES  victim line, byte 0 in bits [7:0].
REQ-019 mem_rdata  input  8*LINE_BYTES  refill line; sampled in the mem_ack cycle.
REQ-020 mem_ack  input  1  one-cycle completion; ignored while mem_req=0.

Function
REQ-021 Address split: offset = low log2(LINE_BYTES) bits, index = next log2(SETS) bits, tag = remaining upper bits.
REQ-022 FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
REQ-023 req_ready = 1 only in IDLE; acceptance when req_valid & req_ready; request fields are registered at acceptance.
REQ-024 IDLE -> LOOKUP on acceptance. LOOKUP compares the tag against all ways of the indexed set; a hit requires valid = 1 and a tag match.
REQ-025 LOOKUP hit -> RESPOND; resp_valid is high in the cycle after LOOKUP, so hit latency is 2 cycles from acceptance to resp_valid.
REQ-026 LOOKUP miss victim: the lowest-index invalid way; if no way is invalid, the LRU way. Dirty victim -> WRITEBACK, else -> REFILL.
REQ-027 WRITEBACK: mem_req = 1, mem_we = 1, mem_addr = {victim tag, index, 0}, mem_wdata = victim line; on mem_ack -> REFILL.
REQ-028 REFILL: mem_req = 1, mem_we = 0, mem_addr = {req tag, index, 0}; on mem_ack, install mem_rdata, tag, valid = 1, dirty = 0 -> RESPOND.
REQ-029 mem_req, mem_we, mem_addr and mem_wdata stay stable from assertion until the mem_ack cycle inclusive; mem_req is 0 in the following cycle unless the next state is REFILL.
REQ-030 Write policy is write-back, write-allocate. A write, hit or miss, updates the addressed byte of the line and sets dirty = 1. The write takes effect in the RESPOND cycle; on a miss it merges after the refill.
REQ-031 RESPOND: resp_valid = 1 for exactly one cycle; resp_rdata = line byte at offset after any write; resp_hit = lookup result. RESPOND -> IDLE.
REQ-032 LRU state: per set, one log2(WAYS)-bit age per way, ages a permutation of 0..WAYS-1, with 0 = most recent.
REQ-033 LRU update on every hit or refill: the accessed way's age becomes 0; ways whose age was less than its old age increment by 1; others are unchanged.
REQ-034 LRU way = the way with age WAYS-1.
REQ-035 Outside RESPOND, resp_valid = 0, and resp_rdata and resp_hit hold their last values.
REQ-036 Only one request is outstanding at a time; there is no hit-under-miss.

Reset
REQ-037 While reset = 1 at a clock edge: state = IDLE; all valid and dirty bits = 0; way w age = w; req_ready = 0 during reset; resp_valid, resp_rdata, resp_hit, mem_req, mem_we and mem_addr = 0.
REQ-038 Reset mid-WRITEBACK or mid-REFILL aborts the operation with no memory retry; mem_req is 0 from the first reset edge; a late mem_ack is ignored.
REQ-039 Data arrays need no reset; an invalid line is never returned.

Verification (WAYS=4, SETS=8, LINE_BYTES=32; index = addr[7:5])
REQ-040 Read miss at 0x9876ABC0, mem_rdata = 0x…123456 -> refill with mem_addr = 0x9876ABC0, no write-back, resp_rdata = 0x56, resp_hit = 0.
REQ-041 Write 0xAA to 0x9876ABC0 after REQ-040 -> resp_hit = 1, no mem_req, resp_valid 2 cycles after acceptance; a following read returns 0xAA.
REQ-042 Write miss of 0xBB to 0x12345678 with mem_rdata = 0x…666666 -> refill at 0x12345660, resp_hit = 0, resp_rdata = 0xBB, line dirty.
REQ-043 Four more distinct tags in set 6 (0x000000C0, 0x100000C0, 0x200000C0, 0x300000C0) -> the fourth evicts the 0x9876ABC0 line: write-back at 0x9876ABC0 with mem_wdata[7:0] = 0xAA, then refill.
REQ-044 Hit on the oldest way, then a new-tag miss -> the victim is the next-oldest way, not the one just hit.
REQ-045 Reset asserted during REFILL with mem_ack withheld -> mem_req = 0 next cycle, a late mem_ack is ignored, and a re-read of the same address misses.

Source files
------------

// File: rtl/set_assoc_cache_if.sv
// Bundles the CPU request/response and memory-side line transfer signals of
// the set-associative cache.
// slave  : cache side (accepts requests, issues memory transactions).
// master : environment side (CPU that issues requests, memory that answers).
interface set_assoc_cache_if #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDR_W-1:0]       req_addr;
    logic [7:0]              req_wdata;
    logic                    resp_valid;
    logic [7:0]              resp_rdata;
    logic                    resp_hit;
    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [8*LINE_BYTES-1:0] mem_wdata;
    logic [8*LINE_BYTES-1:0] mem_rdata;
    logic                    mem_ack;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
        output req_ready, resp_valid, resp_rdata, resp_hit,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
        input  req_ready, resp_valid, resp_rdata, resp_hit,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/set_assoc_cache.sv
// Purpose : byte-access, write-back/write-allocate set-associative cache, age-based LRU.
// Latency : hit 2 cycles accept->resp_valid; miss adds refill (and write-back) memory time.
// Backpressure: one request in flight; req_ready only in IDLE, mem side waits on mem_ack.
// Ports: clk, reset (sync, active-high); bus.slave carries req_*/resp_* toward the
// CPU and mem_* toward the next memory level (mem_req held until mem_ack).
module set_assoc_cache #(
    parameter int WAYS       = 4,
    parameter int SETS       = 8,
    parameter int LINE_BYTES = 32,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    set_assoc_cache_if.slave  bus
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int LINE_W = 8 * LINE_BYTES;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
    state_t state;

    logic              valid    [SETS][WAYS];
    logic              dirty    [SETS][WAYS];
    logic [TAG_W-1:0]  tag_arr  [SETS][WAYS];
    logic [LINE_W-1:0] data_arr [SETS][WAYS];
    logic [WAY_W-1:0]  age      [SETS][WAYS];

    // Request captured at acceptance; held until the response leaves.
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic [WAY_W-1:0]  vic_way;

    logic [TAG_W-1:0]  r_tag;
    logic [IDX_W-1:0]  r_idx;
    logic [OFF_W-1:0]  r_off;
    assign r_tag = r_addr[ADDR_W-1 -: TAG_W];
    assign r_idx = r_addr[OFF_W +: IDX_W];
    assign r_off = r_addr[OFF_W-1:0];

    assign bus.req_ready = (state == IDLE) && !reset;

    // Tag compare and victim choice for the indexed set. Scanning downwards
    // lets the lowest-index candidate win.
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] victim;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[r_idx][w] && (tag_arr[r_idx][w] == r_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid[r_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (age[r_idx][w] == WAY_W'(WAYS - 1)) begin
                lru_way = WAY_W'(w);
            end
        end
        victim = inv_found ? inv_way : lru_way;
    end

    // The response is built on the edge that enters RESPOND: the line (cached
    // or freshly refilled) gets the write byte merged, and the returned byte is
    // taken from the merged line so writes echo the byte as written.
    logic              enter_resp;
    logic [WAY_W-1:0]  tgt_way;
    logic [LINE_W-1:0] new_line;
    logic [7:0]        new_byte;

    always_comb begin
        enter_resp = ((state == LOOKUP) && hit) || ((state == REFILL) && bus.mem_ack);
        tgt_way    = (state == REFILL) ? vic_way : hit_way;
        new_line   = (state == REFILL) ? bus.mem_rdata : data_arr[r_idx][hit_way];
        if (r_we) begin
            new_line[{r_off, 3'b000} +: 8] = r_wdata;
        end
        new_byte = new_line[{r_off, 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_hit   <= 1'b0;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                    age[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            bus.resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_we    <= bus.req_we;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        state <= RESPOND;
                    end else begin
                        vic_way     <= victim;
                        bus.mem_req <= 1'b1;
                        if (dirty[r_idx][victim]) begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= {tag_arr[r_idx][victim], r_idx, {OFF_W{1'b0}}};
                            bus.mem_wdata <= data_arr[r_idx][victim];
                            state         <= WRITEBACK;
                        end else begin
                            bus.mem_we   <= 1'b0;
                            bus.mem_addr <= {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            state        <= REFILL;
                        end
                    end
                end
                WRITEBACK: begin
                    // mem_req stays high straight into the refill transaction.
                    if (bus.mem_ack) begin
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        state        <= REFILL;
                    end
                end
                REFILL: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        state       <= RESPOND;
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (enter_resp) begin
                data_arr[r_idx][tgt_way] <= new_line;
                if (state == REFILL) begin
                    tag_arr[r_idx][tgt_way] <= r_tag;
                    valid[r_idx][tgt_way]   <= 1'b1;
                    dirty[r_idx][tgt_way]   <= r_we;
                end else if (r_we) begin
                    dirty[r_idx][tgt_way] <= 1'b1;
                end
                bus.resp_valid <= 1'b1;
                bus.resp_rdata <= new_byte;
                bus.resp_hit   <= (state == LOOKUP);
                // Accessed way becomes youngest; only ways younger than it age.
                for (int w = 0; w < WAYS; w++) begin
                    if (w == int'(tgt_way)) begin
                        age[r_idx][w] <= '0;
                    end else if (age[r_idx][w] < age[r_idx][tgt_way]) begin
                        age[r_idx][w] <= age[r_idx][w] + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache (WAYS=4, SETS=8, LINE_BYTES=32):
// a vector table of requests with hand-computed results and memory traffic,
// followed by reset-state and reset-during-refill sequences.
module tb_set_assoc_cache;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    set_assoc_cache_if #(.ADDR_W(32), .LINE_BYTES(32)) bus ();

    set_assoc_cache #(.WAYS(4), .SETS(8), .LINE_BYTES(32), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [7:0]   wdata;
        logic [255:0] line;
        logic         exp_hit;
        logic [7:0]   exp_rdata;
        logic         exp_wb;
        logic [31:0]  exp_wb_addr;
        logic [4:0]   wb_off;
        logic [7:0]   exp_wb_byte;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [7:0] wdata,
                                input logic [255:0] line, input logic exp_hit,
                                input logic [7:0] exp_rdata, input logic exp_wb,
                                input logic [31:0] wb_addr, input logic [4:0] wb_off,
                                input logic [7:0] wb_byte);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.line = line;
        v.exp_hit = exp_hit; v.exp_rdata = exp_rdata; v.exp_wb = exp_wb;
        v.exp_wb_addr = wb_addr; v.wb_off = wb_off; v.exp_wb_byte = wb_byte;
        return v;
    endfunction

    function automatic logic [255:0] fill(input logic [7:0] b);
        return {32{b}};
    endfunction

    task automatic run_vec(input vec_t v, input int n);
        int           cyc;
        int           memwait;
        int           waitcnt;
        bit           got_resp;
        bit           wb_seen;
        bit           rf_seen;
        bit           stable;
        logic [31:0]  wb_addr;
        logic [7:0]   wb_byte;
        logic [31:0]  rf_addr;
        logic [7:0]   rd;
        logic         hit;
        logic         s_we;
        logic [31:0]  s_addr;
        logic [255:0] s_wdata;
        string        p;
        p = $sformatf("v%0d", n);
        got_resp = 0; wb_seen = 0; rf_seen = 0; stable = 1;
        wb_addr = '0; wb_byte = '0; rf_addr = '0; rd = '0; hit = 1'b0;
        s_we = 1'b0; s_addr = '0; s_wdata = '0;

        waitcnt = 0;
        @(negedge clk);
        while (!bus.req_ready && waitcnt < 20) begin
            @(negedge clk);
            waitcnt++;
        end
        if (!bus.req_ready) chk({p, " ready timeout"}, 1'b0, 1'b1);

        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;

        cyc = 0;
        memwait = 0;
        while (!got_resp && cyc < 60) begin
            @(negedge clk);
            cyc++;
            bus.mem_ack = 1'b0;
            if (bus.resp_valid) begin
                got_resp = 1;
                rd  = bus.resp_rdata;
                hit = bus.resp_hit;
            end else if (bus.mem_req) begin
                if (memwait == 0) begin
                    s_we = bus.mem_we; s_addr = bus.mem_addr; s_wdata = bus.mem_wdata;
                end else if (s_we !== bus.mem_we || s_addr !== bus.mem_addr ||
                             s_wdata !== bus.mem_wdata) begin
                    stable = 0;
                end
                memwait++;
                if (memwait == 2) begin
                    if (bus.mem_we) begin
                        wb_seen = 1;
                        wb_addr = bus.mem_addr;
                        wb_byte = bus.mem_wdata[{v.wb_off, 3'b000} +: 8];
                    end else begin
                        rf_seen = 1;
                        rf_addr = bus.mem_addr;
                        bus.mem_rdata = v.line;
                    end
                    bus.mem_ack = 1'b1;
                    memwait = 0;
                end
            end
        end

        chk({p, " resp_valid seen"}, got_resp, 1'b1);
        chk({p, " resp_hit"}, hit, v.exp_hit);
        chk({p, " resp_rdata"}, rd, v.exp_rdata);
        chk({p, " writeback seen"}, wb_seen, v.exp_wb);
        chk({p, " refill seen"}, rf_seen, !v.exp_hit);
        chk({p, " mem stable"}, stable, 1'b1);
        if (v.exp_hit) chk({p, " hit latency"}, cyc, 2);
        if (!v.exp_hit) chk({p, " refill addr"}, rf_addr, {v.addr[31:5], 5'b0});
        if (v.exp_wb) begin
            chk({p, " wb addr"}, wb_addr, v.exp_wb_addr);
            chk({p, " wb byte"}, wb_byte, v.exp_wb_byte);
        end
        @(negedge clk);
        chk({p, " resp_valid one cycle"}, bus.resp_valid, 1'b0);
        chk({p, " mem_req idle"}, bus.mem_req, 1'b0);
    endtask

    vec_t vecs [18];

    initial begin
        int waitcnt;
        vec_t rv;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;

        //           we   addr          wd     line             hit  rdata wb  wb_addr      off  wb_byte
        vecs[0]  = mk(1'b0, 32'h9876ABC0, 8'h00, 256'h123456,     1'b0, 8'h56, 1'b0, 32'h0,        5'd0,  8'h00);
        vecs[1]  = mk(1'b1, 32'h9876ABC0, 8'hAA, 256'h0,          1'b1, 8'hAA, 1'b0, 32'h0,        5'd0,  8'h00);
        vecs[2]  = mk(1'b0, 32'h9876ABC0, 8'h00, 256'h0,          1'b1, 8'hAA, 1'b0, 32'h0,        5'd0,  8'h00);
        vecs[3]  = mk(1'b1, 32'h12345678, 8'hBB, fill(8'h66),     1'b0, 8'hBB, 1'b0, 32'h0,        5'd0,  8'h00);
        vecs[4]  = mk(1'b0, 32'h12345678, 8'h00, 256'h0,          1'b1, 8'hBB, 1'b0, 32'h0,        5'd0,  8'h00);
        vecs[5]  = mk(1'b0, 32'h12345679, 8'h00, 256'h0,          1'b1, 8'h66, 1'b0, 32'h0,        5'd0,  8'h00);
        vecs[6]  = mk(1'b0, 32'h000000C0, 8'h00, fill(8'h10),     1'b0, 8'h10, 1'b0, 32'h0,        5'd0,  8'h00);
        vecs[7]  = mk(1'b0, 32'h100000C0, 8'h00, fill(8'h20),     1'b0, 8'h20, 1'b0, 32'h0,        5'd0,  8'h00);
        vecs[8]  = mk(1'b0, 32'h200000C0, 8'h00, fill(8'h30),     1'b0, 8'h30, 1'b0, 32'h0,        5'd0,  8'h00);
        vecs[9]  = mk(1'b0, 32'h300000C0, 8'h00, fill(8'h40),     1'b0, 8'h40, 1'b1, 32'h9876ABC0, 5'd0,  8'hAA);
        vecs[10] = mk(1'b0, 32'h000000C0, 8'h00, 256'h0,          1'b1, 8'h10, 1'b0, 32'h0,        5'd0,  8'h00);
        vecs[11] = mk(1'b0, 32'h400000C0, 8'h00, fill(8'h50),     1'b0, 8'h50, 1'b0, 32'h0,        5'd0,  8'h00);
        vecs[12] = mk(1'b0, 32'h000000C0, 8'h00, 256'h0,          1'b1, 8'h10, 1'b0, 32'h0,        5'd0,  8'h00);
        vecs[13] = mk(1'b0, 32'h100000C0, 8'h00, fill(8'h21),     1'b0, 8'h21, 1'b0, 32'h0,        5'd0,  8'h00);
        vecs[14] = mk(1'b0, 32'h00000060, 8'h00, fill(8'h61),     1'b0, 8'h61, 1'b0, 32'h0,        5'd0,  8'h00);
        vecs[15] = mk(1'b0, 32'h10000060, 8'h00, fill(8'h62),     1'b0, 8'h62, 1'b0, 32'h0,        5'd0,  8'h00);
        vecs[16] = mk(1'b0, 32'h20000060, 8'h00, fill(8'h63),     1'b0, 8'h63, 1'b0, 32'h0,        5'd0,  8'h00);
        vecs[17] = mk(1'b0, 32'h30000060, 8'h00, fill(8'h64),     1'b0, 8'h64, 1'b1, 32'h12345660, 5'd24, 8'hBB);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst req_ready", bus.req_ready, 1'b0);
        chk("rst resp_valid", bus.resp_valid, 1'b0);
        chk("rst resp_rdata", bus.resp_rdata, 8'h00);
        chk("rst resp_hit", bus.resp_hit, 1'b0);
        chk("rst mem_req", bus.mem_req, 1'b0);
        chk("rst mem_we", bus.mem_we, 1'b0);
        chk("rst mem_addr", bus.mem_addr, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post-rst req_ready", bus.req_ready, 1'b1);

        for (int i = 0; i < 18; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset while a refill is waiting for its ack.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h55555500;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        waitcnt = 0;
        @(negedge clk);
        while (!bus.mem_req && waitcnt < 20) begin
            @(negedge clk);
            waitcnt++;
        end
        chk("abort mem_req raised", bus.mem_req, 1'b1);
        chk("abort mem_we", bus.mem_we, 1'b0);
        chk("abort mem_addr", bus.mem_addr, 32'h55555500);
        reset = 1'b1;
        @(negedge clk);
        chk("abort mem_req dropped", bus.mem_req, 1'b0);
        chk("abort req_ready in reset", bus.req_ready, 1'b0);
        reset = 1'b0;
        bus.mem_rdata = fill(8'hEE);
        bus.mem_ack   = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("late ack resp_valid", bus.resp_valid, 1'b0);
        chk("late ack mem_req", bus.mem_req, 1'b0);
        chk("late ack req_ready", bus.req_ready, 1'b1);
        repeat (2) begin
            @(negedge clk);
            chk("late ack quiet", bus.resp_valid, 1'b0);
        end

        // Both the aborted line and a formerly dirty line miss cleanly after reset.
        rv = mk(1'b0, 32'h55555500, 8'h00, fill(8'h77), 1'b0, 8'h77, 1'b0, 32'h0, 5'd0, 8'h00);
        run_vec(rv, 100);
        rv = mk(1'b0, 32'h9876ABC0, 8'h00, fill(8'h88), 1'b0, 8'h88, 1'b0, 32'h0, 5'd0, 8'h00);
        run_vec(rv, 101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
